// File: rtl/rv32_wb_arbiter.sv
// Writeback arbiter for ALU/LSU with a pending-load scoreboard.
// Define RV32_WB_ARB_RR_EN for round-robin arbitration; fixed ALU priority otherwise.
module rv32_wb_arbiter #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned NR     = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              alu_valid_i,
   input  logic [ADDR_W-1:0] alu_waddr_i,
   input  logic [XLEN-1:0]   alu_wdata_i,
   output logic              alu_ready_o,
   input  logic              lsu_valid_i,
   input  logic [ADDR_W-1:0] lsu_waddr_i,
   input  logic [XLEN-1:0]   lsu_wdata_i,
   output logic              lsu_ready_o,
   input  logic              iss_valid_i,
   input  logic [ADDR_W-1:0] iss_rd_i,
   output logic              iss_ready_o,
   input  logic [ADDR_W-1:0] raddr_a_i,
   input  logic [ADDR_W-1:0] raddr_b_i,
   output logic              stall_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic [NR-1:0]     busy_o
);

   logic              alu_win;
   logic              alu_fire;
   logic              lsu_fire;
   logic              iss_fire;
   logic [NR-1:0]     busy_q;
   logic [NR-1:0]     busy_d;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [XLEN-1:0]   wdata_q;

`ifdef RV32_WB_ARB_RR_EN
   typedef enum logic {LAST_ALU, LAST_LSU} rr_e;
   rr_e rr_q;
   rr_e rr_d;

   always_comb begin
      rr_d = rr_q;
      if (alu_fire)
         rr_d = LAST_ALU;
      else if (lsu_fire)
         rr_d = LAST_LSU;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)
         rr_q <= LAST_LSU;
      else
         rr_q <= rr_d;
   end

   assign alu_win = (rr_q == LAST_LSU);
`else
   assign alu_win = 1'b1;
`endif

   // alu_win only matters when both requesters are valid
   assign alu_ready_o = alu_valid_i & (~lsu_valid_i | alu_win);
   assign lsu_ready_o = lsu_valid_i & (~alu_valid_i | ~alu_win);
   assign alu_fire    = alu_ready_o;
   assign lsu_fire    = lsu_ready_o;

   // A load completing to the same register frees the slot for a re-issue this cycle
   assign iss_ready_o = ~busy_q[iss_rd_i] | (lsu_fire & (lsu_waddr_i == iss_rd_i));
   assign iss_fire    = iss_valid_i & iss_ready_o;

   always_comb begin
      busy_d = busy_q;
      if (lsu_fire)
         busy_d[lsu_waddr_i] = 1'b0;
      if (iss_fire && (iss_rd_i != '0))
         busy_d[iss_rd_i] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= 1'b0;
         if (alu_fire) begin
            we_q    <= (alu_waddr_i != '0);
            waddr_q <= alu_waddr_i;
            wdata_q <= alu_wdata_i;
         end else if (lsu_fire) begin
            we_q    <= (lsu_waddr_i != '0);
            waddr_q <= lsu_waddr_i;
            wdata_q <= lsu_wdata_i;
         end
      end
   end

   always_comb begin
      stall_o = 1'b0;
      if (busy_q[raddr_a_i] && (raddr_a_i != '0))
         stall_o = 1'b1;
      if (busy_q[raddr_b_i] && (raddr_b_i != '0))
         stall_o = 1'b1;
   end

   assign we_o    = we_q;
   assign waddr_o = waddr_q;
   assign wdata_o = wdata_q;
   assign busy_o  = busy_q;

endmodule

// File: doc/rv32_wb_arbiter.md
RV32_WB_ARBITER -- requirements
Module: rv32_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
  - XLEN, default 32, data word width.
  - NR, default 32, number of architectural registers.
  - ADDR_W, default 5, register address width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
  - clk_i, in, 1, the single clock.
  - rst_n, in, 1, asynchronous active-low reset.
  - alu_valid_i, in, 1, ALU writeback request.
  - alu_waddr_i, in, ADDR_W, ALU destination register.
  - alu_wdata_i, in, XLEN, ALU result.
  - alu_ready_o, out, 1, ALU request accepted this cycle.
  - lsu_valid_i, in, 1, load-unit writeback request.
  - lsu_waddr_i, in, ADDR_W, load destination register.
  - lsu_wdata_i, in, XLEN, load data.
  - lsu_ready_o, out, 1, load request accepted this cycle.
  - iss_valid_i, in, 1, a load is being issued.
  - iss_rd_i, in, ADDR_W, destination register of the issued load.
  - iss_ready_o, out, 1, issue permitted (no WAW conflict).
  - raddr_a_i, in, ADDR_W, decode source register A.
  - raddr_b_i, in, ADDR_W, decode source register B.
  - stall_o, out, 1, RAW hazard on a pending load.
  - we_o, out, 1, register-file write enable.
  - waddr_o, out, ADDR_W, register-file write address.
  - wdata_o, out, XLEN, register-file write data.
  - busy_o, out, NR, scoreboard of pending load destinations.
REQ-003 Clock and reset SHALL be one clock, clk_i, and one reset, rst_n, asynchronous and active-low.

Function
REQ-004 The block SHALL grant at most one writeback per cycle.
  - A transfer completes when valid and ready are both high at a rising edge.
  - ready SHALL be combinational from the valids and the arbitration state.
REQ-005 With a single requester valid, that requester SHALL be granted (ready=1) in the same cycle.
REQ-006 With both requesters valid, the winner SHALL be chosen per REQ-017.
  - The loser's ready SHALL be 0.
  - The loser SHALL hold its valid, address and data stable until it is granted.
REQ-007 we_o, waddr_o and wdata_o SHALL be registered, giving one-cycle latency:
  - a transfer accepted at edge N drives we_o=1 with its address and data during cycle N+1;
  - if nothing is accepted at an edge, we_o SHALL be 0 in the following cycle.
REQ-008 A transfer with waddr=0 SHALL complete its handshake, but we_o SHALL stay 0.
REQ-009 An issue with iss_valid_i=1, iss_ready_o=1 and iss_rd_i≠0 SHALL set busy_o[iss_rd_i] at that edge.
  - An issue with rd=0 SHALL set no bit.
REQ-010 iss_ready_o SHALL be 0 while busy_o[iss_rd_i]=1, unless an LSU transfer to the same register completes in that cycle.
REQ-011 An accepted LSU transfer SHALL clear busy_o[lsu_waddr_i] at the acceptance edge.
  - If an issue sets the same register at the same edge, the set SHALL win.
REQ-012 ALU transfers SHALL NOT modify busy_o.
REQ-013 stall_o SHALL equal (busy_o[raddr_a_i] AND raddr_a_i≠0) OR (busy_o[raddr_b_i] AND raddr_b_i≠0).
  - stall_o SHALL be purely combinational.
REQ-014 busy_o[0] SHALL always be 0.

Reset
REQ-015 While rst_n=0, and asynchronously on its assertion, the block SHALL reset to:
  - we_o=0, waddr_o=0, wdata_o=0;
  - busy_o all zeros;
  - round-robin pointer = "LSU granted last".
REQ-016 Asserting reset mid-operation SHALL discard all pending scoreboard state and any registered write.
  - The first cycle after deassertion SHALL have we_o=0.

Configuration
REQ-017 Macro RV32_WB_ARB_RR_EN SHALL select the arbitration policy.
  - Defined: round-robin. On conflict, the requester not granted most recently wins. The pointer updates on every grant (single or conflicting).
  - Undefined: fixed priority, ALU always wins on conflict, and no pointer register exists.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
  - ALU only: alu_valid=1, waddr=5, wdata=0x1234 at edge N → alu_ready=1 in cycle N; we_o=1, waddr_o=5, wdata_o=0x1234 in cycle N+1.
  - Conflict: ALU (rd 3) and LSU (rd 4) both valid for 2 cycles.
    - RR_EN defined: cycle 1 grants ALU, cycle 2 grants LSU.
    - RR_EN undefined: ALU is granted in both cycles.
  - Scoreboard: issue rd=7, then raddr_a=7 → stall_o=1 and iss_ready_o=0 for rd=7; LSU writeback rd=7 accepted at edge M → busy_o[7]=0 and stall_o=0 in cycle M+1.
  - Same-edge set/clear: LSU writeback rd=9 and issue rd=9 at the same edge → busy_o[9]=1 afterwards.
  - x0: ALU transfer waddr=0 → handshake completes, we_o stays 0; issue rd=0 → busy_o stays 0, stall_o=0 for raddr=0.
  - Reset mid-operation: busy_o=0x0000_0080 and we_o=1, then rst_n pulsed low → busy_o=0 and we_o=0 immediately; we_o=0 in the first cycle after release.
